// File: rtl/match_sequencer.sv
// Match flow controller for a two-player ball game: start synchronisation, serve
// countdown, live rally with hit-based speed steps, post-point pause and match end.
module match_sequencer #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 8,
  parameter int PAUSE_TICKS = 16
) (
  input  logic       clkMain,
  input  logic       rstN,
  input  logic       btnStart,
  input  logic       tick,
  input  logic       pointA,
  input  logic       pointB,
  input  logic       hit,
  output logic       playing,
  output logic       ballReset,
  output logic       serveDir,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic [1:0] winner,
  output logic [1:0] speedLevel,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       ball_reset_q, ball_reset_d;
  logic       playing_q, playing_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic [2:0] live_q;
  logic       start_edge;
  logic [3:0] score_a_inc, score_b_inc;

  // live_q fills with ones after reset release; an edge is only trusted once the
  // previous-sample flop holds a real button sample, so a held button never starts.
  always_ff @(posedge clkMain or negedge rstN) begin
    if (!rstN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      live_q  <= 3'b000;
    end else begin
      sync1_q <= btnStart;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      live_q  <= {live_q[1:0], 1'b1};
    end
  end

  assign start_edge  = sync2_q & ~sync3_q & live_q[2];
  assign score_a_inc = score_a_q + 4'd1;
  assign score_b_inc = score_b_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    hit_cnt_d    = hit_cnt_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_reset_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          score_a_d    = 4'd0;
          score_b_d    = 4'd0;
          winner_d     = 2'b00;
          serve_dir_d  = 1'b1;
          timer_d      = 8'(SERVE_TICKS);
          hit_cnt_d    = 4'd0;
          ball_reset_d = 1'b1;
          state_d      = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (timer_q <= 8'd1) state_d = S_RALLY;
          else                 timer_d = timer_q - 8'd1;
        end
      end
      S_RALLY: begin
        // pointA has priority over pointB; a point masks a coincident hit.
        if (pointA) begin
          score_a_d = score_a_inc;
          if (score_a_inc == 4'(WIN_SCORE)) begin
            winner_d = 2'b01;
            state_d  = S_OVER;
          end else begin
            timer_d     = 8'(PAUSE_TICKS);
            serve_dir_d = 1'b1;
            state_d     = S_POINT;
          end
        end else if (pointB) begin
          score_b_d = score_b_inc;
          if (score_b_inc == 4'(WIN_SCORE)) begin
            winner_d = 2'b10;
            state_d  = S_OVER;
          end else begin
            timer_d     = 8'(PAUSE_TICKS);
            serve_dir_d = 1'b0;
            state_d     = S_POINT;
          end
        end else if (hit && hit_cnt_q != 4'd15) begin
          hit_cnt_d = hit_cnt_q + 4'd1;
        end
      end
      S_POINT: begin
        if (tick) begin
          if (timer_q <= 8'd1) begin
            timer_d      = 8'(SERVE_TICKS);
            hit_cnt_d    = 4'd0;
            ball_reset_d = 1'b1;
            state_d      = S_SERVE;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    playing_d = (state_d == S_RALLY);
  end

  always_ff @(posedge clkMain or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      score_a_q    <= 4'd0;
      score_b_q    <= 4'd0;
      hit_cnt_q    <= 4'd0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      hit_cnt_q    <= hit_cnt_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      ball_reset_q <= ball_reset_d;
      playing_q    <= playing_d;
    end
  end

  assign playing    = playing_q;
  assign ballReset  = ball_reset_q;
  assign serveDir   = serve_dir_q;
  assign scoreA     = score_a_q;
  assign scoreB     = score_b_q;
  assign winner     = winner_q;
  assign speedLevel = hit_cnt_q[3:2];
  assign state      = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: a vector table for the opening point plus
// hand sequences for winning, contention, ignored start and asynchronous reset.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       btn, tk, pa, pb, ht;
  logic       playing, ballReset, serveDir;
  logic [3:0] scoreA, scoreB;
  logic [1:0] winner, speedLevel;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       btn, tk, pa, pb, ht;
    logic [2:0] st;
    logic       pl;
    logic [3:0] sa, sb;
    logic [1:0] win;
    logic       sd;
    logic [1:0] spd;
    logic       br;
  } vec_t;

  vec_t vecs[$];

  match_sequencer dut (
    .clkMain(clk), .rstN(rstN), .btnStart(btn), .tick(tk),
    .pointA(pa), .pointB(pb), .hit(ht),
    .playing(playing), .ballReset(ballReset), .serveDir(serveDir),
    .scoreA(scoreA), .scoreB(scoreB), .winner(winner),
    .speedLevel(speedLevel), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic t, input logic a, input logic bb, input logic h);
    @(negedge clk);
    btn = b; tk = t; pa = a; pb = bb; ht = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic pl,
                         input logic [3:0] sa, input logic [3:0] sb, input logic [1:0] win,
                         input logic sd, input logic [1:0] spd, input logic br);
    chk({tag, ".state"},      8'(state),      8'(st));
    chk({tag, ".playing"},    8'(playing),    8'(pl));
    chk({tag, ".scoreA"},     8'(scoreA),     8'(sa));
    chk({tag, ".scoreB"},     8'(scoreB),     8'(sb));
    chk({tag, ".winner"},     8'(winner),     8'(win));
    chk({tag, ".serveDir"},   8'(serveDir),   8'(sd));
    chk({tag, ".speedLevel"}, 8'(speedLevel), 8'(spd));
    chk({tag, ".ballReset"},  8'(ballReset),  8'(br));
  endtask

  function automatic void add(input logic b, input logic t, input logic a, input logic bb,
                              input logic h, input logic [2:0] st, input logic pl,
                              input logic [3:0] sa, input logic [3:0] sb, input logic [1:0] win,
                              input logic sd, input logic [1:0] spd, input logic br);
    vec_t v;
    v.btn = b; v.tk = t; v.pa = a; v.pb = bb; v.ht = h;
    v.st = st; v.pl = pl; v.sa = sa; v.sb = sb; v.win = win;
    v.sd = sd; v.spd = spd; v.br = br;
    vecs.push_back(v);
  endfunction

  initial begin
    rstN = 1'b0; btn = 1'b0; tk = 1'b0; pa = 1'b0; pb = 1'b0; ht = 1'b0;

    // Opening point: idle, start, serve countdown, 13 hits, pointB, pause.
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,1,1,1,1, 0,0,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0,1,0,1);
    add(0,0,1,0,1, 1,0,0,0,0,1,0,0);
    for (int i = 1; i <= 7; i++) add(0,1,0,0,0, 1,0,0,0,0,1,0,0);
    add(0,1,0,0,0, 2,1,0,0,0,1,0,0);
    for (int h = 1; h <= 13; h++) begin
      add(0,0,0,0,1, 2,1,0,0,0,1, 2'((h / 4 > 3) ? 3 : h / 4), 0);
      if (h == 6) add(0,1,0,0,0, 2,1,0,0,0,1,1,0);
    end
    add(0,0,0,1,1, 3,0,0,1,0,0,3,0);
    add(0,0,1,0,1, 3,0,0,1,0,0,3,0);
    for (int i = 1; i <= 15; i++) add(0,1,0,0,0, 3,0,0,1,0,0,3,0);
    add(0,1,0,0,0, 1,0,0,1,0,0,0,1);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0,0,0,0,0,0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].btn, vecs[i].tk, vecs[i].pa, vecs[i].pb, vecs[i].ht);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pl, vecs[i].sa, vecs[i].sb,
              vecs[i].win, vecs[i].sd, vecs[i].spd, vecs[i].br);
    end

    // Player A takes six points.
    for (int k = 1; k <= 6; k++) begin
      repeat (8) step(0,1,0,0,0);
      chk($sformatf("a%0d.rally", k), 8'(state), 8'd2);
      step(0,0,1,0,0);
      chk_all($sformatf("a%0d.point", k), 3, 0, 4'(k), 1, 0, 1, 0, 0);
      repeat (16) step(0,1,0,0,0);
      chk_all($sformatf("a%0d.serve", k), 1, 0, 4'(k), 1, 0, 1, 0, 1);
    end
    repeat (8) step(0,1,0,0,0);
    chk_all("rally6", 2,1,6,1,0,1,0,0);

    // Start button during a rally is ignored.
    repeat (5) step(1,0,0,0,0);
    chk_all("btn_rally", 2,1,6,1,0,1,0,0);
    repeat (3) step(0,0,0,0,0);

    // Simultaneous points: A wins the match, B's point is dropped.
    step(0,0,1,1,0);
    chk_all("win", 4,0,7,1,1,1,0,0);
    repeat (3) step(0,1,1,1,1);
    chk_all("over_hold", 4,0,7,1,1,1,0,0);

    step(1,0,0,0,0);
    step(1,0,0,0,0);
    chk("restart.wait", 8'(state), 8'd4);
    step(1,0,0,0,0);
    chk_all("restart", 1,0,0,0,0,1,0,1);

    // New match: A scores, next rally builds speed, then reset mid-rally.
    repeat (8) step(0,1,0,0,0);
    repeat (5) step(0,0,0,0,1);
    step(0,0,1,0,0);
    chk_all("m2.point", 3,0,1,0,0,1,1,0);
    repeat (16) step(0,1,0,0,0);
    chk_all("m2.serve", 1,0,1,0,0,1,0,1);
    repeat (8) step(0,1,0,0,0);
    repeat (4) step(0,0,0,0,1);
    chk_all("m2.rally", 2,1,1,0,0,1,1,0);

    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk_all("async_reset", 0,0,0,0,0,0,0,0);

    // Button held high across reset release must not start a match.
    btn = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) step(1,0,0,0,0);
    chk_all("held_btn", 0,0,0,0,0,0,0,0);
    repeat (2) step(0,0,0,0,0);
    repeat (3) step(1,0,0,0,0);
    chk_all("post_reset_start", 1,0,0,0,0,1,0,1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
